// File: rtl/pool_column_feeder_if.sv
// Pixel-stream in / pooling-column out bundle for pool_column_feeder.
// slave = feeder side, master = upstream producer / pooling consumer side.
interface pool_column_feeder_if #(
  parameter int DATA_W = 16
);
  logic                   pixel_valid;
  logic [DATA_W-1:0]      pixel_in;
  logic                   pixel_ready;
  logic                   valid_out;
  logic [1:0][DATA_W-1:0] column_out;
  logic                   frame_done;

  modport slave (
    input  pixel_valid, pixel_in,
    output pixel_ready, valid_out, column_out, frame_done
  );

  modport master (
    output pixel_valid, pixel_in,
    input  pixel_ready, valid_out, column_out, frame_done
  );
endinterface

// File: rtl/pool_column_feeder.sv
// Row-major pixel stream -> vertical {even,odd} row columns for 2x2 max-pool.
// COLUMN_FEEDER_PAD_EN: odd IMG_H allowed; last row is paired with PAD_VALUE.
module pool_column_feeder #(
  parameter int                        DATA_W    = 16,
  parameter int                        IMG_W     = 24,
  parameter int                        IMG_H     = 24,
  parameter logic signed [DATA_W-1:0]  PAD_VALUE = 16'sh8000
) (
  input  logic                 clk,
  input  logic                 rst,
  pool_column_feeder_if.slave  bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 1);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_w
    $error("pool_column_feeder: IMG_W must be even and >= 2");
  end
`ifndef COLUMN_FEEDER_PAD_EN
  if ((IMG_H % 2) != 0) begin : g_bad_h
    $error("pool_column_feeder: odd IMG_H needs COLUMN_FEEDER_PAD_EN");
  end
`endif

  typedef enum logic [1:0] {
    FILL_TOP,
    PAIR
`ifdef COLUMN_FEEDER_PAD_EN
    , PAD
`endif
  } state_t;

  state_t                 r_state;
  logic [XW-1:0]          r_x;
  logic [RW-1:0]          r_row;
  logic                   r_valid;
  logic                   r_done;
  logic [1:0][DATA_W-1:0] r_col;
  logic [DATA_W-1:0]      r_linebuf [IMG_W];

  logic w_ready, w_acc, w_x_last, w_row_last;

`ifdef COLUMN_FEEDER_PAD_EN
  logic r_ready;
  assign w_ready = r_ready;
`else
  assign w_ready = 1'b1;
`endif

  assign w_acc      = bus.pixel_valid && w_ready;
  assign w_x_last   = (r_x == XW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));

  // Top row lives here until its odd partner row streams past; never reset.
  always_ff @(posedge clk) begin
    if ((r_state == FILL_TOP) && w_acc)
      r_linebuf[r_x] <= bus.pixel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL_TOP;
      r_x     <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_col   <= '0;
`ifdef COLUMN_FEEDER_PAD_EN
      r_ready <= 1'b1;
`endif
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        FILL_TOP: if (w_acc) begin
          r_x <= w_x_last ? '0 : r_x + XW'(1);
          if (w_x_last) begin
`ifdef COLUMN_FEEDER_PAD_EN
            if (w_row_last) begin
              r_state <= PAD;
              r_ready <= 1'b0;
            end else
`endif
            begin
              r_row   <= r_row + RW'(1);
              r_state <= PAIR;
            end
          end
        end
        PAIR: if (w_acc) begin
          r_valid <= 1'b1;
          r_col   <= {bus.pixel_in, r_linebuf[r_x]};
          r_done  <= w_x_last && w_row_last;
          r_x     <= w_x_last ? '0 : r_x + XW'(1);
          if (w_x_last) begin
            r_row   <= w_row_last ? '0 : r_row + RW'(1);
            r_state <= FILL_TOP;
          end
        end
`ifdef COLUMN_FEEDER_PAD_EN
        // Upstream is stalled while the buffered last row drains against pad.
        PAD: begin
          r_valid <= 1'b1;
          r_col   <= {PAD_VALUE, r_linebuf[r_x]};
          r_x     <= w_x_last ? '0 : r_x + XW'(1);
          if (w_x_last) begin
            r_done  <= 1'b1;
            r_row   <= '0;
            r_ready <= 1'b1;
            r_state <= FILL_TOP;
          end
        end
`endif
        default: r_state <= FILL_TOP;
      endcase
    end
  end

  assign bus.pixel_ready = w_ready;
  assign bus.valid_out   = r_valid;
  assign bus.column_out  = r_col;
  assign bus.frame_done  = r_done;

endmodule

// File: tb/tb_pool_column_feeder.sv
// Randomized + directed bench for pool_column_feeder against a frame-array model.
// Works in both the default build and with COLUMN_FEEDER_PAD_EN (odd height).
module tb_pool_column_feeder;
  localparam int W = 4;
`ifdef COLUMN_FEEDER_PAD_EN
  localparam int H = 3;
`else
  localparam int H = 2;
`endif
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_column_feeder_if #(.DATA_W(16)) bus ();

  pool_column_feeder #(
    .DATA_W(16), .IMG_W(W), .IMG_H(H), .PAD_VALUE(16'sh8000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  // Model: pixel position within the frame plus a copy of the frame so far.
  logic [15:0] frame [N];
  int          pos;
  int          pad_cnt;
  logic        exp_v, exp_done, exp_rdy;
  logic [31:0] exp_col;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(bit r, bit v, logic [15:0] d);
    int x, row;
    rst             = r;
    bus.pixel_valid = v;
    bus.pixel_in    = d;
    @(posedge clk);
    exp_v    = 1'b0;
    exp_done = 1'b0;
    if (r) begin
      pos     = 0;
      pad_cnt = 0;
      exp_col = '0;
    end else if (pad_cnt > 0) begin
      x        = W - pad_cnt;
      exp_v    = 1'b1;
      exp_col  = {16'h8000, frame[(H - 1) * W + x]};
      pad_cnt--;
      exp_done = (pad_cnt == 0);
    end else if (v && exp_rdy) begin
      row        = pos / W;
      frame[pos] = d;
      if (row % 2 == 1) begin
        exp_v    = 1'b1;
        exp_col  = {d, frame[pos - W]};
        exp_done = (pos == N - 1);
      end else if (pos == N - 1) begin
        pad_cnt = W;
      end
      pos = (pos == N - 1) ? 0 : pos + 1;
    end
    exp_rdy = (pad_cnt == 0);
    @(negedge clk);
    chk("valid_out", 32'(bus.valid_out), 32'(exp_v));
    chk("frame_done", 32'(bus.frame_done), 32'(exp_done));
    chk("pixel_ready", 32'(bus.pixel_ready), 32'(exp_rdy));
    if (exp_v || r) chk("column_out", bus.column_out, exp_col);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    exp_rdy         = 1'b1;
    rst             = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    idle(2);

    // continuous frame 1..N
    for (int i = 1; i <= N; i++) step(1'b0, 1'b1, 16'(i));
    idle(W + 2);

    // alternating bubbles
    for (int i = 1; i <= N; i++) begin
      step(1'b0, 1'b1, 16'(i));
      step(1'b0, 1'b0, 16'hdead);
    end
    idle(W + 2);

    // two frames back-to-back, driven continuously (model stalls on pad)
    for (int i = 1; i <= 2 * N; i++) begin
      while (!exp_rdy) step(1'b0, 1'b1, 16'hbeef);
      step(1'b0, 1'b1, 16'(i));
    end
    idle(W + 2);

    // reset mid-frame, then a fresh frame
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 16'(i));
    step(1'b1, 1'b0, 16'h0);
    for (int i = 20; i < 20 + N; i++) step(1'b0, 1'b1, 16'(i));
    idle(W + 2);

    // signed extremes on top row, 0x0001 everywhere else
    begin
      logic [15:0] ext [4];
      ext = '{16'h7fff, 16'h8000, 16'hffff, 16'h0000};
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, (i < W) ? ext[i] : 16'h0001);
    end
    idle(W + 2);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 16'h0);
      else step(1'b0, ($urandom_range(0, 3) != 0), 16'($urandom));
    end
    idle(W + 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
